// File: rtl/alu_defs_pkg.sv
// Shared definitions for the decode/operand stage and the ALU it feeds:
// ALU opcode encoding, RV32I major opcodes and the sign-extension helper.
package alu_defs_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SRL  = 4'd3,
    ALU_SRA  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Sign-extend a 12-bit immediate to the full datapath width.
  function automatic logic signed [XLEN-1:0] sext12(input logic [11:0] imm);
    logic signed [11:0] s;
    s = signed'(imm);
    return XLEN'(s);
  endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// Two-read / one-write register file. x0 always reads zero, writes to x0
// are dropped, and a same-cycle write to a read address is forwarded.
module reg_file_2r1w
  import alu_defs_pkg::*;
#(
  parameter int              NREGS     = 32,
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NREGS];

  // Storage: reset clears every entry; reset dominates a concurrent write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  // Read ports with write-through bypass; x0 is forced to zero.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != 5'd0) rd1 = (we && wa == ra1) ? wd : regs[ra1];
    if (ra2 != 5'd0) rd2 = (we && wa == ra2) ? wd : regs[ra2];
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Decode/operand stage in front of the ALU: reads rs1/rs2, builds the
// immediate, selects both operands and decodes the ALU opcode, all in the
// same cycle as the instruction is presented.
module alu_operand_stage
  import alu_defs_pkg::*;
#(
  parameter int              NREGS     = 32,
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] in_1,
  output logic [XLEN-1:0] in_2,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] rs2_data,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       f7_base, f7_alt;

  logic [XLEN-1:0]        rs1_val, rs2_val;
  logic signed [XLEN-1:0] imm_i, imm_s;
  logic [XLEN-1:0]        imm_u, shamt_i, shamt_r;

  logic [XLEN-1:0] op_a, op_b;
  alu_op_e         ctrl;
  logic            bad;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign f7_base = (funct7 == F7_BASE);
  assign f7_alt  = (funct7 == F7_ALT);

  assign imm_i   = sext12(instr[31:20]);
  assign imm_s   = sext12({instr[31:25], instr[11:7]});
  assign imm_u   = {instr[31:12], 12'b0};
  assign shamt_i = {27'b0, instr[24:20]};
  assign shamt_r = {27'b0, rs2_val[4:0]};

  reg_file_2r1w #(
    .NREGS    (NREGS),
    .RESET_VAL(RESET_VAL)
  ) u_rf (
    .clk  (clk),
    .rst_n(rst_n),
    .ra1  (instr[19:15]),
    .ra2  (instr[24:20]),
    .rd1  (rs1_val),
    .rd2  (rs2_val),
    .we   (wb_en),
    .wa   (wb_addr),
    .wd   (wb_data)
  );

  // Opcode/funct decode and operand selection; unsupported encodings
  // collapse to a zero-operand ADD flagged as illegal.
  always_comb begin
    op_a = '0;
    op_b = '0;
    ctrl = ALU_ADD;
    bad  = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        op_a = rs1_val;
        op_b = rs2_val;
        bad  = !f7_base;
        unique case (funct3)
          3'b000: begin ctrl = f7_alt ? ALU_SUB : ALU_ADD; bad = !(f7_base || f7_alt); end
          3'b001: begin ctrl = ALU_SLL; op_b = shamt_r; end
          3'b010: ctrl = ALU_SLT;
          3'b011: ctrl = ALU_SLTU;
          3'b100: ctrl = ALU_XOR;
          3'b101: begin
            ctrl = f7_alt ? ALU_SRA : ALU_SRL;
            op_b = shamt_r;
            bad  = !(f7_base || f7_alt);
          end
          3'b110: ctrl = ALU_OR;
          3'b111: ctrl = ALU_AND;
        endcase
      end
      OPC_OP_IMM: begin
        op_a = rs1_val;
        op_b = imm_i;
        unique case (funct3)
          3'b000: ctrl = ALU_ADD;
          3'b001: begin ctrl = ALU_SLL; op_b = shamt_i; bad = !f7_base; end
          3'b010: ctrl = ALU_SLT;
          3'b011: ctrl = ALU_SLTU;
          3'b100: ctrl = ALU_XOR;
          3'b101: begin
            ctrl = f7_alt ? ALU_SRA : ALU_SRL;
            op_b = shamt_i;
            bad  = !(f7_base || f7_alt);
          end
          3'b110: ctrl = ALU_OR;
          3'b111: ctrl = ALU_AND;
        endcase
      end
      OPC_LOAD: begin
        op_a = rs1_val;
        op_b = imm_i;
      end
      OPC_STORE: begin
        op_a = rs1_val;
        op_b = imm_s;
      end
      OPC_BRANCH: begin
        op_a = rs1_val;
        op_b = rs2_val;
        unique case (funct3[2:1])
          2'b00: ctrl = ALU_SUB;
          2'b01: bad  = 1'b1;
          2'b10: ctrl = ALU_SLT;
          2'b11: ctrl = ALU_SLTU;
        endcase
      end
      OPC_LUI: op_b = imm_u;
      OPC_AUIPC: begin
        op_a = pc;
        op_b = imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        op_a = pc;
        op_b = XLEN'(4);
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      op_a = '0;
      op_b = '0;
      ctrl = ALU_ADD;
    end
  end

  // Outputs are held at a neutral ADD of zeros while reset is asserted.
  assign in_1     = rst_n ? op_a : '0;
  assign in_2     = rst_n ? op_b : '0;
  assign alu_ctrl = rst_n ? ctrl : ALU_ADD;
  assign rs2_data = rst_n ? rs2_val : '0;
  assign illegal  = rst_n & bad;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: the driver applies one vector per
// cycle and queues its hand-computed response; a monitor on the falling
// edge pops and compares whenever an expectation is pending.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr, pc, wb_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] in_1, in_2, rs2_data;
  logic [3:0]  alu_ctrl;
  logic        illegal;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic [31:0] r2;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0033;

  alu_operand_stage dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .instr   (instr),
    .pc      (pc),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .in_1    (in_1),
    .in_2    (in_2),
    .alu_ctrl(alu_ctrl),
    .rs2_data(rs2_data),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  task automatic apply(input string nm, input logic rst, input logic [31:0] ins,
                       input logic [31:0] p, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [31:0] ea, input logic [31:0] eb,
                       input logic [3:0] ec, input logic [31:0] er2, input logic eill);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n   = rst;
    instr   = ins;
    pc      = p;
    wb_en   = we;
    wb_addr = wa;
    wb_data = wd;
    e.name = nm; e.a = ea; e.b = eb; e.c = ec; e.r2 = er2; e.ill = eill;
    exp_q.push_back(e);
  endtask

  // Monitor: compare outputs mid-cycle against the oldest pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (in_1 !== e.a || in_2 !== e.b || alu_ctrl !== e.c ||
          rs2_data !== e.r2 || illegal !== e.ill) begin
        errors++;
        $display("FAIL %s: got in_1=%h in_2=%h alu_ctrl=%0d rs2_data=%h illegal=%b, expected in_1=%h in_2=%h alu_ctrl=%0d rs2_data=%h illegal=%b",
                 e.name, in_1, in_2, alu_ctrl, rs2_data, illegal,
                 e.a, e.b, e.c, e.r2, e.ill);
      end
    end
  end

  initial begin
    rst_n = 1'b0; instr = NOP; pc = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (2) @(posedge clk);

    // Reset behaviour
    apply("wr_x3",      1, NOP, 0, 1, 5'd3, 32'h55, 0, 0, 0, 0, 0);
    apply("rd_x3_pre",  1, enc(7'h00, 5'd3, 5'd3, 3'b000, 5'd0, 7'h33), 0, 0, 0, 0,
          32'h55, 32'h55, 0, 32'h55, 0);
    apply("rst_outputs", 0, 32'h0000_007F, 32'h40, 1, 5'd4, 32'h99, 0, 0, 0, 0, 0);
    apply("rd_x3_x4",   1, enc(7'h00, 5'd4, 5'd3, 3'b000, 5'd0, 7'h33), 0, 0, 0, 0,
          0, 0, 0, 0, 0);
    for (int n = 1; n < 32; n++)
      apply($sformatf("rst_x%0d", n), 1, enc(7'h00, 5'(n), 5'(n), 3'b000, 5'd0, 7'h33),
            0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Register writes and R-type
    apply("wr_x5", 1, NOP, 0, 1, 5'd5, 32'h7,  0, 0, 0, 0, 0);
    apply("wr_x6", 1, NOP, 0, 1, 5'd6, 32'h3,  0, 0, 0, 0, 0);
    apply("wr_x8", 1, NOP, 0, 1, 5'd8, 32'h25, 0, 0, 0, 0, 0);
    apply("sub",   1, 32'h4062_83B3, 0, 0, 0, 0, 32'h7, 32'h3, 4'd1, 32'h3, 0);
    apply("sll_mask", 1, enc(7'h00, 5'd8, 5'd5, 3'b001, 5'd1, 7'h33), 0, 0, 0, 0,
          32'h7, 32'h5, 4'd2, 32'h25, 0);

    // Bypass and x0
    apply("bypass_rs1", 1, 32'h0002_80B3, 0, 1, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 0, 0);
    apply("bypass_rs2_sra", 1, enc(7'h20, 5'd6, 5'd5, 3'b101, 5'd1, 7'h33), 0, 1, 5'd6,
          32'h8000_0001, 32'hDEAD_BEEF, 32'h1, 4'd4, 32'h8000_0001, 0);
    apply("wr_x0",   1, 32'h0000_00B3, 0, 1, 5'd0, 32'h5, 0, 0, 0, 0, 0);
    apply("rd_x0",   1, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Immediates and other formats
    apply("addi_m1", 1, 32'hFFF0_0093, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 4'd0, 0, 0);
    apply("srai",    1, 32'h4042_D093, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'h4, 4'd4, 0, 0);
    apply("lw_m8",   1, enc(7'h7F, 5'h18, 5'd5, 3'b010, 5'd1, 7'h03), 0, 0, 0, 0,
          32'hDEAD_BEEF, 32'hFFFF_FFF8, 4'd0, 0, 0);
    apply("sw_p8",   1, enc(7'h00, 5'd6, 5'd5, 3'b010, 5'd8, 7'h23), 0, 0, 0, 0,
          32'hDEAD_BEEF, 32'h8, 4'd0, 32'h8000_0001, 0);
    apply("sw_m4",   1, enc(7'h7F, 5'd0, 5'd5, 3'b010, 5'h1C, 7'h23), 0, 0, 0, 0,
          32'hDEAD_BEEF, 32'hFFFF_FFFC, 4'd0, 0, 0);
    apply("bltu",    1, enc(7'h00, 5'd6, 5'd5, 3'b110, 5'd0, 7'h63), 0, 0, 0, 0,
          32'hDEAD_BEEF, 32'h8000_0001, 4'd9, 32'h8000_0001, 0);
    apply("blt",     1, enc(7'h00, 5'd6, 5'd5, 3'b100, 5'd0, 7'h63), 0, 0, 0, 0,
          32'hDEAD_BEEF, 32'h8000_0001, 4'd8, 32'h8000_0001, 0);
    apply("slt",     1, enc(7'h00, 5'd6, 5'd5, 3'b010, 5'd1, 7'h33), 0, 0, 0, 0,
          32'hDEAD_BEEF, 32'h8000_0001, 4'd8, 32'h8000_0001, 0);
    apply("lui",     1, 32'h1234_50B7, 0, 0, 0, 0, 0, 32'h1234_5000, 4'd0, 0, 0);
    apply("auipc",   1, 32'h0000_0097, 32'h100, 0, 0, 0, 32'h100, 0, 4'd0, 0, 0);
    apply("jal",     1, 32'h0000_006F, 32'h200, 0, 0, 0, 32'h200, 32'h4, 4'd0, 0, 0);

    // Illegal encodings
    apply("bad_opcode", 1, 32'h0000_007F, 32'h300, 0, 0, 0, 0, 0, 0, 0, 1);
    apply("slli_f7",    1, 32'h4042_9093, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    apply("xor_f7",     1, enc(7'h20, 5'd0, 5'd5, 3'b100, 5'd1, 7'h33), 0, 0, 0, 0,
          0, 0, 0, 0, 1);
    apply("branch_f3",  1, enc(7'h00, 5'd0, 5'd5, 3'b010, 5'd0, 7'h63), 0, 0, 0, 0,
          0, 0, 0, 0, 1);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
